// File: rtl/led_code_sequencer.sv
// Round-robin blink-code scheduler: grants the single status LED to one requester,
// plays N blinks plus a gap, then releases it. Outputs are registered.
module led_code_sequencer #(
  parameter int N_REQ     = 4,
  parameter int CNT_W     = 4,
  parameter int TICK_DIV  = 25_000_000,
  parameter int GAP_TICKS = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*CNT_W-1:0]   code,
  output logic [N_REQ-1:0]         gnt,
  output logic                     busy,
  output logic                     done,
  output logic                     led
);

  localparam int GAP_CYC = GAP_TICKS * TICK_DIV;
  localparam int MAX_CYC = (GAP_CYC > TICK_DIV) ? GAP_CYC : TICK_DIV;
  localparam int PH_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [PH_W-1:0]  TICK_LAST = PH_W'(TICK_DIV - 1);
  localparam logic [PH_W-1:0]  GAP_LAST  = PH_W'(GAP_CYC - 1);
  localparam logic [PTR_W-1:0] OWN_LAST  = PTR_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] REM_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [PH_W-1:0]   ph;
  logic [CNT_W-1:0]  rem;
  logic [PTR_W-1:0]  owner;
  logic [PTR_W-1:0]  ptr;

  logic              found;
  logic [PTR_W-1:0]  win;
  logic [CNT_W-1:0]  win_code;
  logic              grant;
  logic              ph_tick_end;
  logic              ph_gap_end;

  logic [N_REQ-1:0]  gnt_nxt;
  logic              busy_nxt;
  logic              done_nxt;
  logic              led_nxt;

  // The pointer is the slot after the last owner; owner resets to the top index
  // so requester 0 starts with highest priority.
  always_comb begin
    ptr = (owner == OWN_LAST) ? '0 : owner + 1'b1;
  end

  // Round-robin pick: first set request scanning upward from ptr with wrap.
  always_comb begin
    int j;
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int off = 0; off < N_REQ; off++) begin
      j = int'(ptr) + off;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req[j]) begin
        found = 1'b1;
        win   = PTR_W'(j);
      end
    end
  end

  assign win_code    = code[win*CNT_W +: CNT_W];
  assign grant       = (state == S_IDLE) && found;
  assign ph_tick_end = (ph == TICK_LAST);
  assign ph_gap_end  = (ph == GAP_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (found) state_nxt = (win_code != '0) ? S_ON : S_GAP;
      end
      S_ON: begin
        if (ph_tick_end) state_nxt = (rem == REM_ONE) ? S_GAP : S_OFF;
      end
      S_OFF: begin
        if (ph_tick_end) state_nxt = S_ON;
      end
      S_GAP: begin
        if (ph_gap_end) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic, computed one cycle ahead so every output leaves a flop.
  always_comb begin
    led_nxt  = (state_nxt == S_ON);
    gnt_nxt  = grant ? (N_REQ'(1) << win) : '0;
    done_nxt = (state == S_GAP) && (state_nxt == S_IDLE);
    busy_nxt = (state_nxt != S_IDLE) || done_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led  <= 1'b0;
      gnt  <= '0;
      done <= 1'b0;
      busy <= 1'b0;
    end else begin
      led  <= led_nxt;
      gnt  <= gnt_nxt;
      done <= done_nxt;
      busy <= busy_nxt;
    end
  end

  // Phase counter restarts on every transition and is held at zero in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= '0;
    end else if ((state == S_IDLE) || (state_nxt != state)) begin
      ph <= '0;
    end else begin
      ph <= ph + 1'b1;
    end
  end

  // rem only decrements at the end of an ON phase, which is entered with rem >= 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem   <= '0;
      owner <= OWN_LAST;
    end else if (grant) begin
      rem   <= win_code;
      owner <= win;
    end else if ((state == S_ON) && ph_tick_end) begin
      rem   <= rem - 1'b1;
    end
  end

endmodule

// File: tb/tb_led_code_sequencer.sv
// Directed bench for led_code_sequencer with TICK_DIV=4, GAP_TICKS=2, 4 requesters.
module tb_led_code_sequencer;

  localparam int T = 4;
  localparam int G = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req = '0;
  logic [15:0] code = '0;
  logic [3:0]  gnt;
  logic        busy;
  logic        done;
  logic        led;

  int n_tests = 0;
  int n_fail  = 0;

  led_code_sequencer #(
    .N_REQ(4), .CNT_W(4), .TICK_DIV(T), .GAP_TICKS(G)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .code(code),
    .gnt(gnt), .busy(busy), .done(done), .led(led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] code;
    logic [15:0] new_code;
    logic [3:0]  exp_gnt;
    int          exp_cyc;
    int          exp_blinks;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit exp_led(input int o, input int k);
    if (o < (2*k - 1) * T) return ((o / T) % 2) == 0;
    return 1'b0;
  endfunction

  task automatic wait_gnt(output logic [3:0] g, output bit ok);
    ok = 1'b0;
    g  = '0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (gnt != 4'd0) begin
        g  = gnt;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic play(input vec_t v, input int id);
    logic [3:0] g;
    bit ok;
    int cyc;
    int blinks;
    int led_bad;
    bit prev;
    bit got_done;
    req  = v.req;
    code = v.code;
    wait_gnt(g, ok);
    chk($sformatf("v%0d_gnt_seen", id), 32'(ok), 32'd1);
    if (!ok) begin
      req = '0;
      return;
    end
    chk($sformatf("v%0d_gnt", id), 32'(g), 32'(v.exp_gnt));
    chk($sformatf("v%0d_busy_at_gnt", id), 32'(busy), 32'd1);
    req      = '0;
    code     = v.new_code;
    cyc      = 0;
    blinks   = led ? 1 : 0;
    prev     = led;
    led_bad  = (led !== exp_led(0, v.exp_blinks)) ? 1 : 0;
    got_done = 1'b0;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk($sformatf("v%0d_gnt_pulse", id), 32'(gnt), 32'd0);
      if (led && !prev) blinks++;
      prev = led;
      if (led !== exp_led(cyc, v.exp_blinks)) led_bad++;
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    chk($sformatf("v%0d_done_seen", id), 32'(got_done), 32'd1);
    chk($sformatf("v%0d_gnt_to_done", id), 32'(cyc), 32'(v.exp_cyc));
    chk($sformatf("v%0d_blinks", id), 32'(blinks), 32'(v.exp_blinks));
    chk($sformatf("v%0d_led_pattern_errs", id), 32'(led_bad), 32'd0);
    chk($sformatf("v%0d_busy_at_done", id), 32'(busy), 32'd1);
    @(negedge clk);
    chk($sformatf("v%0d_done_one_cycle", id), 32'(done), 32'd0);
    chk($sformatf("v%0d_busy_after", id), 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] g;
    logic [3:0] order [4];
    bit ok;
    int cyc;
    int bad;
    int rises;
    bit prev;

    vecs[0] = '{4'b0010, 16'h0030, 16'h0030, 4'b0010,  28,  3};
    vecs[1] = '{4'b1000, 16'h0000, 16'h0000, 4'b1000,   8,  0};
    vecs[2] = '{4'b0001, 16'h000F, 16'h000F, 4'b0001, 124, 15};
    vecs[3] = '{4'b0010, 16'h0020, 16'h0070, 4'b0010,  20,  2};
    vecs[4] = '{4'b0100, 16'h0100, 16'h0100, 4'b0100,  12,  1};

    // Asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #2;
    chk("reset_outputs", 32'({led, busy, done, gnt}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ({led, busy, done, gnt} != 7'd0) bad++;
    end
    chk("idle_50_cycles_nonzero", 32'(bad), 32'd0);

    for (int i = 0; i < 5; i++) play(vecs[i], i);

    // Round-robin: requesters 0 and 2 held, both code 1
    order[0] = 4'b0001; order[1] = 4'b0100; order[2] = 4'b0001; order[3] = 4'b0100;
    req  = 4'b0101;
    code = 16'h0101;
    wait_gnt(g, ok);
    chk("rr_first_gnt_seen", 32'(ok), 32'd1);
    for (int i = 0; i < 4 && ok; i++) begin
      chk($sformatf("rr%0d_gnt", i), 32'(g), 32'(order[i]));
      cyc = 0;
      while (cyc < 100) begin
        @(negedge clk);
        cyc++;
        if (done) break;
      end
      chk($sformatf("rr%0d_gnt_to_done", i), 32'(cyc), 32'd12);
      if (i == 3) begin
        req = '0;
      end else begin
        cyc = 0;
        g   = '0;
        while (cyc < 20) begin
          @(negedge clk);
          cyc++;
          if (gnt != 4'd0) begin
            g = gnt;
            break;
          end
        end
        chk($sformatf("rr%0d_done_to_next_gnt", i), 32'(cyc), 32'd1);
      end
    end
    req = '0;
    repeat (3) @(negedge clk);

    // Abort code 5 on requester 2 during its 2nd ON phase
    req  = 4'b0100;
    code = 16'h0500;
    wait_gnt(g, ok);
    chk("abort_gnt", 32'(g), 32'b0100);
    req   = '0;
    rises = 1;
    prev  = led;
    for (int i = 0; i < 100 && rises < 2; i++) begin
      @(negedge clk);
      if (led && !prev) rises++;
      prev = led;
    end
    chk("abort_second_on_reached", 32'(rises), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outputs_immediate", 32'({led, busy, done, gnt}), 32'd0);
    req = 4'b1100;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done || led || gnt != 4'd0) bad++;
    end
    chk("abort_held_quiet", 32'(bad), 32'd0);
    rst_n = 1'b1;
    wait_gnt(g, ok);
    chk("after_reset_gnt", 32'(g), 32'b0100);
    req = '0;
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done) break;
    end
    chk("after_reset_gnt_to_done", 32'(cyc), 32'd44);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_code_sequencer.md
# led_code_sequencer

Blink-code scheduler for the board's single status LED. Several requesters share the LED. Each requester asks to display a blink code (N blinks, then a gap). The block arbitrates round-robin, plays one complete code per grant, and releases the LED. It sits between the status sources and the `led` pin, and replaces free-running toggle logic.

## Interface
- `N_REQ`, default 4: number of requesters.
- `CNT_W`, default 4: width of each blink-count field.
- `TICK_DIV`, default 25_000_000: clock cycles per ON or OFF phase (0.5 s at 50 MHz). Must be ≥ 2.
- `GAP_TICKS`, default 2: length of the inter-code gap, in phases.
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req`, in, N_REQ: level request, one bit per requester.
- `code`, in, N_REQ*CNT_W: blink count for requester i, in bits [i*CNT_W +: CNT_W].
- `gnt`, out, N_REQ: one-hot, 1-cycle pulse when a request is accepted.
- `busy`, out, 1: high while a code is playing (any state other than IDLE).
- `done`, out, 1: 1-cycle pulse at the end of the gap.
- `led`, out, 1: LED drive, active high.

## Operation
- States:
  - IDLE
  - ON
  - OFF
  - GAP
- Registers:
  - phase counter, width clog2(GAP_TICKS*TICK_DIV)
  - remaining-blink counter `rem`, CNT_W bits
  - round-robin pointer `ptr`
  - latched owner index
- IDLE, no request: `led`=0 and no pulses.
- IDLE, `req` nonzero:
  - Select the first set bit, scanning from `ptr` upward with wrap.
  - Pulse `gnt[i]`.
  - Latch `code[i]` into `rem`.
  - Set `ptr` = (i+1) mod N_REQ.
  - Clear the phase counter.
  - If latched code ≠ 0: go to ON and set `led`=1.
  - If latched code = 0: go to GAP and keep `led`=0.
- ON: after TICK_DIV cycles, set `led`=0 and decrement `rem`.
  - If the decremented value is 0, go to GAP.
  - Otherwise go to OFF.
- OFF: after TICK_DIV cycles, set `led`=1 and go to ON.
- GAP: after GAP_TICKS*TICK_DIV cycles, pulse `done` and go to IDLE.
- Requests are level-sensitive:
  - The requester deasserts `req` on seeing `gnt`.
  - A request still held after its code finishes is re-eligible, at lowest priority because of the pointer rotation.
- `code` is sampled only at grant. Changes while `busy` are ignored.
- `req` changes while `busy` are ignored. Arbitration occurs only in IDLE.
- No preemption. A started code always completes unless reset is asserted.

## Timing
- Reset values, applied immediately on `rst_n` low, independent of `clk`:
  - state = IDLE
  - `led`=0, `gnt`=0, `done`=0, `busy`=0
  - `ptr`=0 (requester 0 has highest priority)
  - counters = 0
- All outputs are registered.
- Grant edge: `gnt` rises and, for nonzero codes, `led` rises in the same cycle.
- `busy` is high from the cycle after the grant edge through the cycle in which `done` is high.
- Code k ≥ 1: `done` asserts (2k−1)*TICK_DIV + GAP_TICKS*TICK_DIV cycles after `gnt`.
- Code 0: `done` asserts GAP_TICKS*TICK_DIV cycles after `gnt`.
- Earliest next grant is the cycle after `done`. A back-to-back grant is therefore exactly 1 cycle after `done`.
- Reset mid-sequence aborts immediately, with no `done` pulse.
- The pointer returns to 0, so the first grant after reset goes to the lowest-index active requester.
- Counter wrap: phase counters clear on every state transition, so they never free-run.
- Maximum code 2^CNT_W−1 is played fully; `rem` never underflows.

## Test plan
All scenarios use TICK_DIV=4, GAP_TICKS=2, N_REQ=4, CNT_W=4.
- **Reset check.** Assert `rst_n`=0 mid-cycle. Required: `led`, `gnt`, `busy`, `done` all 0 without waiting for a `clk` edge. After release with no `req`, all stay 0 for 50 cycles.
- **Single code 3.** `req[1]`=1 with code 3, dropped after `gnt`. Required:
  - `gnt`=4'b0010 for 1 cycle.
  - `led` pattern: 1 for 4 cycles, 0 for 4, 1 for 4, 0 for 4, 1 for 4, then 0.
  - `done` pulse exactly 28 cycles after `gnt`.
- **Round-robin.** `req[0]` and `req[2]` both held high, both with code 1. Required:
  - Grant order 0, 2, 0, 2.
  - Each grant occurs 1 cycle after the previous `done`.
  - 12 cycles from each `gnt` to its `done`.
- **Zero code.** `req[3]` with code 0. Required: `led` never rises; `done` 8 cycles after `gnt`.
- **Sampling and abort.**
  - Change `code[1]` from 2 to 7 while 2 is playing. Required: exactly 2 blinks.
  - Then start code 5 on requester 2 and pull `rst_n` low during the 2nd ON phase. Required: `led`=0 at once and no `done`.
  - After release with `req[3]` and `req[2]` both set, `gnt[2]` is issued first (pointer reset to 0).
- **Maximum code.** Code 15. Required: 15 rising `led` edges, then `done` at 29*4 + 8 = 124 cycles after `gnt`.
